// File: rtl/kmap_lut_engine.sv
// Runtime-loadable 2^NIN-entry truth table (value + care planes) with a census scan FSM.
// Eval latency 1 cycle, in_ready = !out_valid | out_ready; cfg_ready is low while scanning.
module kmap_lut_engine #(
    parameter int                  NIN       = 4,
    parameter logic [2**NIN-1:0]   INIT_VAL  = 16'hDD0C,
    parameter logic [2**NIN-1:0]   INIT_CARE = 16'hDDEF,
    parameter int                  DC_MODE   = 0,
    parameter int                  CW        = NIN + 1
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NIN-1:0] in_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_bit,
    output logic           out_dc,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [NIN-1:0] cfg_addr,
    input  logic           cfg_val,
    input  logic           cfg_care,
    input  logic           scan_start,
    output logic           scan_busy,
    output logic           scan_done,
    output logic [CW-1:0]  ones_cnt,
    output logic [CW-1:0]  dc_cnt
);

    localparam int               D        = 2**NIN;
    localparam logic [NIN-1:0]   IDX_LAST = {NIN{1'b1}};
    localparam logic [NIN-1:0]   IDX_INC  = {{(NIN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_INC  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    logic [D-1:0]   r_val;
    logic [D-1:0]   r_care;

    logic           r_out_valid;
    logic           r_out_bit;
    logic           r_out_dc;
    logic           r_last_cared;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NIN-1:0] r_idx;
    logic [NIN-1:0] w_idx_nxt;
    logic [CW-1:0]  r_ones;
    logic [CW-1:0]  w_ones_nxt;
    logic [CW-1:0]  r_dc;
    logic [CW-1:0]  w_dc_nxt;
    logic           r_scan_done;
    logic           w_scan_done_nxt;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_ent_val;
    logic           w_ent_care;
    logic           w_dc_bit;
    logic           w_cfg_ready;
    logic           w_cfg_we;

    // ---------------- evaluate path ----------------
    assign w_in_ready = !r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_ent_val  = r_val[in_vec];
    assign w_ent_care = r_care[in_vec];

    always_comb begin
        w_dc_bit = 1'b0;
        if (DC_MODE == 1) begin
            w_dc_bit = 1'b1;
        end else if (DC_MODE == 2) begin
            w_dc_bit = r_last_cared;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_out_dc     <= 1'b0;
            r_last_cared <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_dc    <= !w_ent_care;
                r_out_bit   <= w_ent_care ? w_ent_val : w_dc_bit;
                if (w_ent_care) begin
                    r_last_cared <= w_ent_val;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ---------------- config path ----------------
    // The lookup above reads the pre-edge table, so a same-cycle write is seen only by later vectors.
    assign w_cfg_ready = (r_state == ST_IDLE);
    assign w_cfg_we    = cfg_valid & w_cfg_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_val  <= INIT_VAL;
            r_care <= INIT_CARE;
        end else if (w_cfg_we) begin
            r_val[cfg_addr]  <= cfg_val;
            r_care[cfg_addr] <= cfg_care;
        end
    end

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_ones      <= '0;
            r_dc        <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ones      <= w_ones_nxt;
            r_dc        <= w_dc_nxt;
            r_scan_done <= w_scan_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_ones_nxt      = r_ones;
        w_dc_nxt        = r_dc;
        w_scan_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scan_start) begin
                    w_ones_nxt  = '0;
                    w_dc_nxt    = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_care[r_idx] & r_val[r_idx]) begin
                    w_ones_nxt = r_ones + CNT_INC;
                end
                if (!r_care[r_idx]) begin
                    w_dc_nxt = r_dc + CNT_INC;
                end
                if (r_idx == IDX_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_scan_done_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_INC;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_dc    = r_out_dc;
    assign cfg_ready = w_cfg_ready;
    assign scan_busy = (r_state == ST_SCAN);
    assign scan_done = r_scan_done;
    assign ones_cnt  = r_ones;
    assign dc_cnt    = r_dc;

endmodule

// File: doc/kmap_lut_engine.md
Name: kmap_lut_engine

Overview:
Programmable truth-table evaluator with don't-care support: a generalised, runtime-loadable Karnaugh-map function of NIN inputs.
- Holds 2^NIN entries. Each entry has a value bit and a care bit.
- Evaluates input vectors through a valid/ready pipeline with a registered output.
- Accepts table writes over a config handshake.
- Has a scan FSM that counts the table's ones and don't-cares.
- Sits between stimulus generators and checkers in the logic-function test fabric.

Parameters:
NIN, 4, number of function inputs (2..8); table depth D = 2^NIN
INIT_VAL, 16'hDD0C, reset value-plane contents, width D, bit i = entry for input i
INIT_CARE, 16'hDDEF, reset care-plane contents, width D, 0 = don't-care
DC_MODE, 0, output for a don't-care entry: 0 = drive 0, 1 = drive 1, 2 = repeat last cared output
CW, NIN+1, width of the scan counters

Ports:
clk  in  1  clock, rising edge
areset  in  1  asynchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  engine can accept a vector
in_vec  in  NIN  input vector {a,b,c,...}; MSB is a
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_bit  out  1  function result
out_dc  out  1  the looked-up entry was a don't-care
cfg_valid  in  1  table write request
cfg_ready  out  1  table write accepted
cfg_addr  in  NIN  entry index
cfg_val  in  1  value bit to write
cfg_care  in  1  care bit to write
scan_start  in  1  start-scan pulse, sampled in IDLE only
scan_busy  out  1  scan FSM is in SCAN
scan_done  out  1  one-cycle pulse when a scan completes
ones_cnt  out  CW  number of entries with care=1 and val=1
dc_cnt  out  CW  number of entries with care=0

Behaviour:
Reset (areset=1, asynchronous):
- Value plane = INIT_VAL; care plane = INIT_CARE.
- out_valid=0, out_bit=0, out_dc=0, last-cared register=0.
- FSM=IDLE, scan_busy=0, scan_done=0, ones_cnt=0, dc_cnt=0.
- Reset mid-scan or mid-transfer abandons the operation; no partial result survives.

Evaluate path:
- in_ready = !out_valid | out_ready.
- A vector is accepted on in_valid & in_ready; its result appears the next cycle with out_valid=1 (latency 1).
- out_bit and out_dc hold stable while out_valid & !out_ready.
- out_valid clears on out_ready when no new vector is accepted the same cycle.
- Back-to-back accept with out_ready held high gives full throughput.
- care=1: out_bit = val, out_dc=0; the last-cared register is updated to val.
- care=0: out_dc=1 and out_bit is set by DC_MODE (0, 1, or the last-cared register). The last-cared register is unchanged.

Config path:
- cfg_ready = (FSM==IDLE).
- On cfg_valid & cfg_ready, entry cfg_addr is written at the clock edge.
- A write and an evaluation of the same address in the same cycle: the evaluation uses the OLD entry.

Scan FSM (IDLE -> SCAN -> IDLE):
- IDLE, scan_start=1: clear both counters, index=0, go to SCAN. cfg_ready drops the following cycle.
- SCAN: one entry per cycle, index 0..D-1. Increment ones_cnt if care&val; increment dc_cnt if !care.
- After entry D-1: return to IDLE, pulse scan_done for exactly one cycle. Total scan length is D cycles.
- Counters hold their values until the next scan_start. CW bits are sufficient for the count D with no wrap.
- scan_start while in SCAN is ignored.
- Evaluation continues during SCAN; the table is frozen during SCAN because cfg_ready=0.

Test Plan:
- Reset defaults, DC_MODE=0, out_ready=1:
  - in_vec=4'h3 -> out_bit=1, out_dc=0 one cycle later.
  - in_vec=4'h4 -> out_bit=0, out_dc=1.
  - in_vec=4'h5 -> out_bit=0, out_dc=0.
- Stream vectors 0..F back-to-back -> 16 results on consecutive cycles:
  - out_bit pattern 16'hDD0C (bit i = result for vector i).
  - out_dc high only for vectors 4, 9 and D.
- out_ready held 0 for 3 cycles after the first result -> in_ready=0, out_bit held stable; no vector lost after release.
- Scan after reset -> scan_busy high for 16 cycles, then a single scan_done pulse, ones_cnt=8, dc_cnt=3. Write addr 9 val=1 care=1, rescan -> ones_cnt=9, dc_cnt=2.
- DC_MODE=2: eval 4'h3 then 4'h9 -> out_bit=1, then 1 with out_dc=1. Eval 4'h5 then 4'hD -> 0, then 0.
- Cfg write to addr 3 (val 0) in the same cycle as eval of 4'h3 -> that result is 1. The next eval of 4'h3 gives 0.
- areset asserted mid-scan -> counters 0, FSM IDLE, table restored to INIT_VAL/INIT_CARE.
